// File: rtl/skinny_round_ctrl.sv
// Control FSM for an 8-rounds-per-cycle SKINNY datapath: load, 5 round cycles, unload.
// Optional macro RCTRL_ABORT_EN adds an abort input that returns the FSM to IDLE.
module skinny_round_ctrl (
    input  logic       clk,
    input  logic       rst,
`ifdef RCTRL_ABORT_EN
    input  logic       abort,
`endif
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       senc,
    output logic       sse,
    output logic       xenc,
    output logic       xse,
    output logic       yenc,
    output logic       yse,
    output logic       zenc,
    output logic       zse,
    output logic [5:0] const0,
    output logic [5:0] const1,
    output logic [5:0] const2,
    output logic [5:0] const3,
    output logic [5:0] const4,
    output logic [5:0] const5,
    output logic [5:0] const6,
    output logic [5:0] const7
);

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, OUT, DONE} state_t;

    state_t      state, state_nx;
    logic [1:0]  beat_cnt, beat_nx;
    logic [2:0]  rnd_cnt, rnd_nx;
    logic [5:0]  rc, rc_nx;
    logic [8:0][5:0] chain;
    logic        kill;

    function automatic logic [5:0] rc_step(input logic [5:0] x);
        return {x[4:0], x[5] ^ x[4] ^ 1'b1};
    endfunction

`ifdef RCTRL_ABORT_EN
    assign kill = abort && (state == LOAD || state == ROUND || state == OUT);
`else
    assign kill = 1'b0;
`endif

    // chain[i+1] is the constant for unrolled round i of this cycle
    always_comb begin
        chain[0] = rc;
        for (int i = 0; i < 8; i++) chain[i+1] = rc_step(chain[i]);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            beat_cnt <= 2'd0;
            rnd_cnt  <= 3'd0;
            rc       <= 6'd0;
        end else begin
            state    <= state_nx;
            beat_cnt <= beat_nx;
            rnd_cnt  <= rnd_nx;
            rc       <= rc_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        beat_nx   = beat_cnt;
        rnd_nx    = rnd_cnt;
        rc_nx     = rc;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        senc      = 1'b0;
        sse       = 1'b0;
        xenc      = 1'b0;
        xse       = 1'b0;
        yenc      = 1'b0;
        yse       = 1'b0;
        zenc      = 1'b0;
        zse       = 1'b0;
        const0    = 6'd0;
        const1    = 6'd0;
        const2    = 6'd0;
        const3    = 6'd0;
        const4    = 6'd0;
        const5    = 6'd0;
        const6    = 6'd0;
        const7    = 6'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                    beat_nx  = 2'd0;
                    rnd_nx   = 3'd0;
                    rc_nx    = 6'd0;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    senc    = 1'b1;
                    sse     = 1'b1;
                    xenc    = 1'b1;
                    xse     = 1'b1;
                    yenc    = 1'b1;
                    yse     = 1'b1;
                    beat_nx = beat_cnt + 2'd1;
                    if (beat_cnt == 2'd3) state_nx = ROUND;
                end
            end
            ROUND: begin
                senc   = 1'b1;
                xenc   = 1'b1;
                yenc   = 1'b1;
                zenc   = 1'b1;
                const0 = chain[1];
                const1 = chain[2];
                const2 = chain[3];
                const3 = chain[4];
                const4 = chain[5];
                const5 = chain[6];
                const6 = chain[7];
                const7 = chain[8];
                rc_nx  = chain[8];
                rnd_nx = rnd_cnt + 3'd1;
                if (rnd_cnt == 3'd4) begin
                    state_nx = OUT;
                    rnd_nx   = 3'd0;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    senc    = 1'b1;
                    sse     = 1'b1;
                    beat_nx = beat_cnt + 2'd1;
                    if (beat_cnt == 2'd3) state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Abort wins over any handshake in flight: no beat is signalled or counted.
        if (kill) begin
            state_nx  = IDLE;
            beat_nx   = 2'd0;
            rnd_nx    = 3'd0;
            rc_nx     = 6'd0;
            in_ready  = 1'b0;
            out_valid = 1'b0;
            senc      = 1'b0;
            sse       = 1'b0;
            xenc      = 1'b0;
            xse       = 1'b0;
            yenc      = 1'b0;
            yse       = 1'b0;
        end
    end

endmodule
